// File: rtl/idelay_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : idelay_pkg
//  Description : Items shared by the frame bitslip aligner and the idelay
//                scanner glue: aligner FSM state encoding, default frame
//                pattern, default slip limit and a lane one-hot helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package idelay_pkg;

    // Aligner FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_FINISH = 3'd5
    } align_state_t;

    // Deserialized frame word an aligned lane presents
    localparam logic [7:0] ALIGN_PATTERN   = 8'hF0;
    // Bitslip pulses allowed per lane before the lane is declared failed
    localparam int         ALIGN_MAX_SLIP  = 8;
    // Width of the lane index bus (3 bits) bounds the lane count
    localparam int         ALIGN_MAX_LANES = 8;

    // One-hot decode of a lane index
    function automatic logic [ALIGN_MAX_LANES-1:0] lane_onehot(input logic [2:0] lane);
        return {{(ALIGN_MAX_LANES-1){1'b0}}, 1'b1} << lane;
    endfunction

endpackage : idelay_pkg
`default_nettype wire

// File: rtl/frame_match_counter.sv
`default_nettype none
// ============================================================================
//  Module      : frame_match_counter
//  Description : Compares the frame word against the expected pattern and
//                counts consecutive matches. The count saturates at NMATCH,
//                restarts on a mismatch while enabled, and clears on i_clr.
//  Ports       : clk, rst_n  - clock, asynchronous active-low reset
//                i_clr       - synchronous clear of the match count
//                i_en        - compare/count enable
//                i_data      - frame word under test
//                o_match     - combinational i_data == PATTERN
//                o_count     - consecutive match count (0..NMATCH)
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_match_counter #(
    parameter logic [7:0] PATTERN = 8'hF0,
    parameter int         NMATCH  = 4,
    localparam int        CW      = $clog2(NMATCH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [7:0]    i_data,
    output logic          o_match,
    output logic [CW-1:0] o_count
);

    localparam logic [CW-1:0] c_NMATCH = CW'(NMATCH);

    logic [CW-1:0] r_count;

    assign o_match = (i_data == PATTERN);
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            if (!o_match) begin
                r_count <= '0;
            end else if (r_count != c_NMATCH) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule : frame_match_counter
`default_nettype wire

// File: rtl/bitslip_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : bitslip_aligner
//  Description : Sequentially aligns the ISERDES frame word of NLANE ADC
//                lanes. For each lane: wait SETTLE cycles, look for NMATCH
//                consecutive PATTERN words, otherwise issue a bitslip and
//                retry, giving up after MAX_SLIP slips.
//
//                Timing: a lane that matches at once costs SETTLE+NMATCH+2
//                cycles (SETTLE settle, NMATCH compares, one cycle to act on
//                the full match count, one NEXT). For a pre-aligned pass,
//                done is high exactly NLANE*(SETTLE+NMATCH+2)+1 cycles after
//                the cycle in which start is high (305 with the defaults).
//
//  Ports       : clk, rst_n     - clock, asynchronous active-low reset
//                start          - one-cycle pulse starting a pass
//                frame_data     - frame word of the selected lane
//                lane_sel       - lane under test (frame mux select)
//                bitslip        - one-hot, one-cycle bitslip pulse
//                busy           - pass in progress
//                done           - one-cycle end-of-pass pulse
//                aligned        - per-lane success flags of the last pass
//                slip_cnt_addr  - slip count readback lane
//                slip_cnt       - slips issued on that lane in the last pass
//  Revision    : 1.0 - initial release
// ============================================================================
module bitslip_aligner
    import idelay_pkg::*;
#(
    parameter int         NLANE    = 8,
    parameter logic [7:0] PATTERN  = ALIGN_PATTERN,
    parameter int         SETTLE   = 32,
    parameter int         NMATCH   = 4,
    parameter int         MAX_SLIP = ALIGN_MAX_SLIP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       frame_data,
    output logic [2:0]       lane_sel,
    output logic [NLANE-1:0] bitslip,
    output logic             busy,
    output logic             done,
    output logic [NLANE-1:0] aligned,
    input  logic [2:0]       slip_cnt_addr,
    output logic [3:0]       slip_cnt
);

    localparam int             SW          = $clog2(SETTLE + 1);
    localparam int             CW          = $clog2(NMATCH + 1);
    localparam logic [SW-1:0]  c_SETTLE_LD = SW'(SETTLE - 1);
    localparam logic [CW-1:0]  c_NMATCH    = CW'(NMATCH);
    localparam logic [3:0]     c_MAX_SLIP  = 4'(MAX_SLIP);
    localparam logic [2:0]     c_LAST_LANE = 3'(NLANE - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    align_state_t     r_state;
    logic [2:0]       r_lane;
    logic [SW-1:0]    r_settle_cnt;
    logic [NLANE-1:0] r_aligned;
    logic [3:0]       r_slip [NLANE];

    // ------------------------------------------------------------------
    // Next-state decode outputs
    // ------------------------------------------------------------------
    align_state_t     w_state_nxt;
    logic             w_settle_load;
    logic             w_clear_pass;
    logic             w_set_aligned;
    logic             w_slip_inc;
    logic             w_lane_inc;
    logic             w_chk_en;

    logic             w_match;
    logic [CW-1:0]    w_count;
    logic [3:0]       w_cur_slip;

    assign w_cur_slip = r_slip[r_lane];

    // Match counter only runs in CHECK; it is held clear everywhere else
    // so every visit to CHECK starts from zero.
    frame_match_counter #(
        .PATTERN (PATTERN),
        .NMATCH  (NMATCH)
    ) u_match (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (r_state != ST_CHECK),
        .i_en    (w_chk_en),
        .i_data  (frame_data),
        .o_match (w_match),
        .o_count (w_count)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_settle_load = 1'b0;
        w_clear_pass  = 1'b0;
        w_set_aligned = 1'b0;
        w_slip_inc    = 1'b0;
        w_lane_inc    = 1'b0;
        w_chk_en      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clear_pass  = 1'b1;
                    w_settle_load = 1'b1;
                    w_state_nxt   = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_state_nxt = ST_CHECK;
                end
            end

            ST_CHECK: begin
                w_chk_en = 1'b1;
                // A full match count is acted on one cycle after the last
                // matching compare, regardless of the word then present.
                if (w_count == c_NMATCH) begin
                    w_set_aligned = 1'b1;
                    w_state_nxt   = ST_NEXT;
                end else if (!w_match) begin
                    if (w_cur_slip == c_MAX_SLIP) begin
                        w_state_nxt = ST_NEXT;
                    end else begin
                        w_state_nxt = ST_SLIP;
                    end
                end
            end

            ST_SLIP: begin
                w_slip_inc    = 1'b1;
                w_settle_load = 1'b1;
                w_state_nxt   = ST_SETTLE;
            end

            ST_NEXT: begin
                if (r_lane == c_LAST_LANE) begin
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_lane_inc    = 1'b1;
                    w_settle_load = 1'b1;
                    w_state_nxt   = ST_SETTLE;
                end
            end

            ST_FINISH: begin
                // start is deliberately not looked at here
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: settle down-counter, lane index, result flags, slip counts
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= '0;
            r_lane       <= '0;
            r_aligned    <= '0;
            for (int i = 0; i < NLANE; i++) begin
                r_slip[i] <= '0;
            end
        end else begin
            if (w_settle_load) begin
                r_settle_cnt <= c_SETTLE_LD;
            end else if ((r_state == ST_SETTLE) && (r_settle_cnt != '0)) begin
                r_settle_cnt <= r_settle_cnt - 1'b1;
            end

            if (w_clear_pass) begin
                r_lane    <= '0;
                r_aligned <= '0;
                for (int i = 0; i < NLANE; i++) begin
                    r_slip[i] <= '0;
                end
            end else begin
                if (w_lane_inc) begin
                    r_lane <= r_lane + 1'b1;
                end
                if (w_set_aligned) begin
                    r_aligned[r_lane] <= 1'b1;
                end
                if (w_slip_inc && (w_cur_slip != c_MAX_SLIP)) begin
                    r_slip[r_lane] <= w_cur_slip + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registered state, so an asynchronous reset
    // forces them to their idle values immediately.
    // ------------------------------------------------------------------
    assign lane_sel = r_lane;
    assign aligned  = r_aligned;
    assign done     = (r_state == ST_FINISH);
    assign busy     = (r_state != ST_IDLE) && (r_state != ST_FINISH);
    assign bitslip  = (r_state == ST_SLIP) ? NLANE'(lane_onehot(r_lane)) : '0;

    always_comb begin
        slip_cnt = '0;
        if (int'(slip_cnt_addr) < NLANE) begin
            slip_cnt = r_slip[slip_cnt_addr];
        end
    end

endmodule : bitslip_aligner
`default_nettype wire

// File: tb/tb_bitslip_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitslip_aligner
//  Description : Scoreboard bench for bitslip_aligner. Stimulus pushes the
//                expected bitslip/done events; a negedge monitor pops and
//                compares them whenever the DUT pulses bitslip or done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bitslip_aligner;

    localparam int NL     = 8;
    localparam int SETTLE = 32;
    // Cycles from the start-high cycle to the done-high cycle, aligned pass:
    // 8 * (32 + 4 + 2) + 1
    localparam int LAT    = 305;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] frame_data;
    logic [2:0] lane_sel;
    logic [7:0] bitslip;
    logic       busy;
    logic       done;
    logic [7:0] aligned;
    logic [2:0] slip_cnt_addr = 3'd0;
    logic [3:0] slip_cnt;

    always #5 clk = ~clk;

    bitslip_aligner dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .frame_data    (frame_data),
        .lane_sel      (lane_sel),
        .bitslip       (bitslip),
        .busy          (busy),
        .done          (done),
        .aligned       (aligned),
        .slip_cnt_addr (slip_cnt_addr),
        .slip_cnt      (slip_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;     // 0 = bitslip pulse, 1 = done pulse
        logic [7:0] val;      // expected bitslip vector or aligned flags
        int         exp_cyc;  // expected monitor cycle for done, -1 = any
    } ev_t;

    ev_t q[$];

    // ---------------- lane frame model ----------------
    int  rot[8];
    int  rot_init[8];
    bit  load_rot = 1'b0;
    bit  stuck[8];
    bit  glitch = 1'b0;
    int  last_slip[8];

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int r);
        if (r == 0) return v;
        return (v << r) | (v >> (8 - r));
    endfunction

    always_comb begin
        frame_data = rotl8(8'hF0, rot[lane_sel]);
        if (stuck[lane_sel]) frame_data = 8'h00;
        if (glitch && (lane_sel == 3'd0)) frame_data = 8'h0F;
    end

    // each bitslip on a rotated lane undoes one bit of rotation
    always @(posedge clk) begin
        for (int l = 0; l < 8; l++) begin
            if (load_rot) rot[l] <= rot_init[l];
            else if (bitslip[l] && (rot[l] > 0)) rot[l] <= rot[l] - 1;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst_n) begin
            if (bitslip != 8'h00) begin
                chk("bitslip_onehot", 32'($onehot(bitslip)), 32'd1);
                for (int l = 0; l < 8; l++) begin
                    if (bitslip[l]) begin
                        if ((last_slip[l] > 0) && (cyc - last_slip[l] < 200))
                            chk("bitslip_spacing", 32'(cyc - last_slip[l] >= SETTLE + 2), 32'd1);
                        last_slip[l] = cyc;
                    end
                end
                if (q.size() == 0) begin
                    chk("unexpected_bitslip", 32'(bitslip), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("bitslip_event_kind", 32'(e.kind), 32'd0);
                    chk("bitslip_lane", 32'(bitslip), 32'(e.val));
                end
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("done_event_kind", 32'(e.kind), 32'd1);
                    chk("done_aligned", 32'(aligned), 32'(e.val));
                    if (e.exp_cyc >= 0) chk("done_latency", 32'(cyc), 32'(e.exp_cyc));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic setup_lanes(input int rl, input int rv, input int sl);
        for (int l = 0; l < 8; l++) begin
            rot_init[l] = (l == rl) ? rv : 0;
            stuck[l]    = (l == sl);
        end
        @(posedge clk); #1 load_rot = 1'b1;
        @(posedge clk); #1 load_rot = 1'b0;
    endtask

    task automatic pulse_start(output int t0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t0 = cyc;
    endtask

    task automatic exp_slips(input int lane, input int n);
        for (int i = 0; i < n; i++) q.push_back('{0, 8'(1 << lane), -1});
    endtask

    task automatic exp_done(input logic [7:0] a, input int c);
        q.push_back('{1, a, c});
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() != 0) && (n < 3000)) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(negedge clk);
        chk("busy_after_pass", 32'(busy), 32'd0);
    endtask

    task automatic chk_slips(input int lane, input int val);
        for (int i = 0; i < 8; i++) begin
            slip_cnt_addr = 3'(i);
            #1;
            chk($sformatf("slip_cnt[%0d]", i), 32'(slip_cnt), (i == lane) ? 32'(val) : 32'd0);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t0;

        setup_lanes(-1, 0, -1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lane_sel", 32'(lane_sel), 32'd0);
        chk("rst_bitslip",  32'(bitslip),  32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_aligned",  32'(aligned),  32'd0);
        chk_slips(-1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // all lanes aligned: no slips, all flags, exact latency
        setup_lanes(-1, 0, -1);
        pulse_start(t0);
        exp_done(8'hFF, t0 - 1 + LAT);
        wait_drain();
        chk_slips(-1, 0);

        // lane 3 rotated by 3: three slips on lane 3
        setup_lanes(3, 3, -1);
        pulse_start(t0);
        exp_slips(3, 3);
        exp_done(8'hFF, -1);
        wait_drain();
        chk_slips(3, 3);

        // lane 5 stuck at 0: eight slips, then give up on the lane
        setup_lanes(-1, 0, 5);
        pulse_start(t0);
        exp_slips(5, 8);
        exp_done(8'hDF, -1);
        wait_drain();
        chk_slips(5, 8);
        chk("lane_sel_final", 32'(lane_sel), 32'd7);

        // lane 0 glitches after three matches: one slip, no early flag
        setup_lanes(-1, 0, -1);
        pulse_start(t0);
        exp_slips(0, 1);
        exp_done(8'hFF, -1);
        repeat (35) @(posedge clk);
        #1 glitch = 1'b1;
        chk("aligned_before_glitch", 32'(aligned), 32'd0);
        @(posedge clk);
        #1 glitch = 1'b0;
        chk("aligned_after_glitch", 32'(aligned), 32'd0);
        wait_drain();
        chk_slips(0, 1);

        // reset during SETTLE of lane 4 aborts the pass
        setup_lanes(-1, 0, -1);
        pulse_start(t0);
        exp_done(8'hFF, -1);
        repeat (158) @(posedge clk);
        #1;
        chk("lane_before_reset", 32'(lane_sel), 32'd4);
        chk("busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_lane_sel", 32'(lane_sel), 32'd0);
        chk("abort_busy",     32'(busy),     32'd0);
        chk("abort_done",     32'(done),     32'd0);
        chk("abort_aligned",  32'(aligned),  32'd0);
        chk("abort_bitslip",  32'(bitslip),  32'd0);
        chk("abort_pending",  32'(q.size()), 32'd1);
        q.delete();
        repeat (5) @(posedge clk);
        chk_slips(-1, 0);
        // start presented for the very first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
        exp_done(8'hFF, t0 - 1 + LAT);
        wait_drain();

        // start while busy and on the FINISH cycle are both ignored
        pulse_start(t0);
        exp_done(8'hFF, t0 - 1 + LAT);
        repeat (100) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc < t0 + LAT - 1) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        chk("finish_done", 32'(done), 32'd1);
        chk("finish_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        wait_drain();
        repeat (400) @(posedge clk);
        #1;
        chk("idle_after_ignored_start", 32'(busy), 32'd0);
        chk("no_pending_events", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bitslip_aligner
`default_nettype wire
